// File: rtl/trail_collision_checker.sv
// trail_collision_checker: per-tick head occupancy check and marking on a 1-bit
// trail bitmap, with a full-board clear sweep.
module trail_collision_checker #(
  parameter int XMAX = 160,
  parameter int YMAX = 120,
  parameter int AW   = 15
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       step_valid,
  input  logic [7:0] p1_x,
  input  logic [7:0] p1_y,
  input  logic [7:0] p2_x,
  input  logic [7:0] p2_y,
  input  logic       clear_req,
  output logic       busy,
  output logic       done,
  output logic       p1_crash,
  output logic       p2_crash,
  output logic       clear_done
);
  typedef enum logic [3:0] {IDLE, RD1, RD2, CHK, WR1, WR2, DONE, CLEAR, CLR_DONE} state_t;
  localparam logic [7:0]    XL   = 8'(XMAX);
  localparam logic [7:0]    YL   = 8'(YMAX);
  localparam logic [AW-1:0] LAST = AW'(XMAX * YMAX - 1);
  state_t        r_state;
  logic [7:0]    r_p1x, r_p1y, r_p2x, r_p2y;
  logic [AW-1:0] r_cnt;
  logic          r_occ1, r_hit1, r_hit2, r_rd;
  logic          r_mem [0:(1<<AW)-1];
  logic          w_in1, w_in2, w_same, w_we, w_wd;
  logic [AW-1:0] w_a1, w_a2, w_addr;
  function automatic logic [AW-1:0] addr_of(input logic [7:0] x, input logic [7:0] y);
    return (AW'(y) << 7) + (AW'(y) << 5) + AW'(x);
  endfunction
  always_comb begin
    w_in1  = (r_p1x < XL) && (r_p1y < YL);
    w_in2  = (r_p2x < XL) && (r_p2y < YL);
    w_same = (r_p1x == r_p2x) && (r_p1y == r_p2y);
    w_a1   = addr_of(r_p1x, r_p1y);
    w_a2   = addr_of(r_p2x, r_p2y);
    w_addr = (r_state == RD2 || r_state == WR2) ? w_a2 : (r_state == CLEAR) ? r_cnt : w_a1;
    w_we   = (r_state == WR1 && w_in1) || (r_state == WR2 && w_in2) || (r_state == CLEAR);
    w_wd   = (r_state != CLEAR);
  end
  // Single-port bitmap with registered read; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (w_we) r_mem[w_addr] <= w_wd;
    r_rd <= r_mem[w_addr];
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      p1_crash   <= 1'b0;
      p2_crash   <= 1'b0;
      clear_done <= 1'b0;
      r_p1x      <= '0;
      r_p1y      <= '0;
      r_p2x      <= '0;
      r_p2y      <= '0;
      r_cnt      <= '0;
      r_occ1     <= 1'b0;
      r_hit1     <= 1'b0;
      r_hit2     <= 1'b0;
    end else begin
      done       <= 1'b0;
      clear_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (clear_req) begin
            r_state  <= CLEAR;
            busy     <= 1'b1;
            r_cnt    <= '0;
            p1_crash <= 1'b0;
            p2_crash <= 1'b0;
          end else if (step_valid) begin
            r_state  <= RD1;
            busy     <= 1'b1;
            r_p1x    <= p1_x;
            r_p1y    <= p1_y;
            r_p2x    <= p2_x;
            r_p2y    <= p2_y;
            p1_crash <= 1'b0;
            p2_crash <= 1'b0;
          end
        end
        RD1: r_state <= RD2;
        RD2: begin
          r_occ1  <= r_rd;
          r_state <= CHK;
        end
        // r_rd now holds the p2 occupancy bit; out-of-bounds heads ignore the RAM.
        CHK: begin
          r_hit1  <= !w_in1 || r_occ1 || w_same;
          r_hit2  <= !w_in2 || r_rd || w_same;
          r_state <= WR1;
        end
        WR1: r_state <= WR2;
        WR2: begin
          r_state  <= DONE;
          done     <= 1'b1;
          p1_crash <= r_hit1;
          p2_crash <= r_hit2;
        end
        CLEAR: begin
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == LAST) begin
            r_state    <= CLR_DONE;
            clear_done <= 1'b1;
          end
        end
        default: begin
          r_state <= IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_trail_collision_checker.sv
// tb_trail_collision_checker: randomized scoreboard bench against a bitmap reference model.
module tb_trail_collision_checker;
  logic       clk = 0, reset_n = 1, step_valid = 0, clear_req = 0;
  logic [7:0] p1_x = 0, p1_y = 0, p2_x = 0, p2_y = 0;
  logic       busy, done, p1_crash, p2_crash, clear_done;
  int total = 0, bad = 0, pc = 0, cd_cnt = 0;
  bit occ [0:255][0:255];
  typedef struct {logic c1; logic c2; int cyc;} exp_t;
  exp_t q[$];

  trail_collision_checker dut (
    .clk(clk), .reset_n(reset_n), .step_valid(step_valid),
    .p1_x(p1_x), .p1_y(p1_y), .p2_x(p2_x), .p2_y(p2_y),
    .clear_req(clear_req), .busy(busy), .done(done),
    .p1_crash(p1_crash), .p2_crash(p2_crash), .clear_done(clear_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) pc++;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (reset_n) begin
      if (clear_done) cd_cnt++;
      if (done) begin
        if (q.size() == 0) chk("unexpected_done", 1, 0);
        else begin
          e = q.pop_front();
          chk("p1_crash", int'(p1_crash), int'(e.c1));
          chk("p2_crash", int'(p2_crash), int'(e.c2));
          chk("done_cycle", pc, e.cyc);
        end
      end
    end
  end

  task automatic do_step(input logic [7:0] x1, input logic [7:0] y1,
                         input logic [7:0] x2, input logic [7:0] y2);
    exp_t e;
    bit in1, in2, same;
    @(posedge clk); #1;
    step_valid = 1; p1_x = x1; p1_y = y1; p2_x = x2; p2_y = y2;
    in1  = (x1 < 160) && (y1 < 120);
    in2  = (x2 < 160) && (y2 < 120);
    same = (x1 == x2) && (y1 == y2);
    e.c1  = !in1 || same || occ[x1][y1];
    e.c2  = !in2 || same || occ[x2][y2];
    e.cyc = pc + 6;
    q.push_back(e);
    if (in1) occ[x1][y1] = 1;
    if (in2) occ[x2][y2] = 1;
    @(posedge clk); #1;
    step_valid = 0;
    for (int i = 0; i < 20 && q.size() != 0; i++) @(posedge clk);
    if (q.size() != 0) begin
      chk("done_timeout", 0, 1);
      q.delete();
    end
  endtask

  task automatic do_clear(input bit with_step, input bit poke);
    int n = 0, cd0;
    @(posedge clk); #1;
    cd0 = cd_cnt;
    clear_req = 1; step_valid = with_step;
    p1_x = 30; p1_y = 30; p2_x = 40; p2_y = 40;
    @(posedge clk); #1;
    clear_req = 0; step_valid = 0;
    while (n < 19300) begin
      @(negedge clk);
      if (!busy) break;
      n++;
      step_valid = poke && (n == 100 || n == 19150);
    end
    step_valid = 0;
    chk("clear_busy_cycles", n, 19201);
    chk("clear_done_pulses", cd_cnt - cd0, 1);
    chk("crash_after_clear", int'({p1_crash, p2_crash}), 0);
    for (int x = 0; x < 256; x++)
      for (int y = 0; y < 256; y++) occ[x][y] = 0;
  endtask

  initial begin
    int cd0;
    logic [7:0] a, b, c, d;
    #2 reset_n = 0;
    #1;
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_crash", int'({p1_crash, p2_crash}), 0);
    chk("rst_clear_done", int'(clear_done), 0);
    repeat (3) @(posedge clk);
    #1 reset_n = 1;

    do_clear(0, 0);
    do_step(10, 10, 150, 110);
    do_step(10, 10, 150, 110);
    do_clear(1, 1);
    do_step(20, 5, 20, 5);
    do_step(21, 5, 19, 5);
    do_step(160, 0, 0, 120);
    do_step(0, 0, 159, 119);

    for (int i = 0; i < 200; i++) begin
      a = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(150, 162));
      b = 8'($urandom_range(112, 122));
      c = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(150, 162));
      d = ($urandom_range(0, 7) == 0) ? b : 8'($urandom_range(112, 122));
      if ($urandom_range(0, 7) == 0) c = a;
      do_step(a, b, c, d);
    end

    // abort a clear sweep partway through with an asynchronous reset
    @(posedge clk); #1;
    clear_req = 1;
    @(posedge clk); #1;
    clear_req = 0;
    cd0 = cd_cnt;
    repeat (5000) @(negedge clk);
    chk("midclear_busy_before", int'(busy), 1);
    #2 reset_n = 0;
    #1;
    chk("midclear_busy", int'(busy), 0);
    chk("midclear_clear_done", int'(clear_done), 0);
    chk("midclear_done", int'(done), 0);
    chk("midclear_crash", int'({p1_crash, p2_crash}), 0);
    repeat (3) @(posedge clk);
    #1 reset_n = 1;
    repeat (30) @(posedge clk);
    #1;
    chk("after_reset_idle", int'(busy), 0);
    chk("no_clear_done_after_abort", cd_cnt - cd0, 0);
    chk("no_pending_steps", q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
